pong_match_ctrl: RTL and testbench
==================================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win a match (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames between ball recentre and ball release.
REQ-003 SHALL have parameter POINT_FRAMES, default 90, frames the ball is held after a point.
REQ-004 SHALL have ports: iclk in 1, the 25 MHz pixel clock; iRST_N in 1, reset. Reset is synchronous and active-low; one clock domain only.
REQ-005 SHALL have ports: iFRAME in 1, one-cycle pulse per video frame (start of vsync); iMISS_L in 1, pulse when the ball passes the left edge; iMISS_R in 1, pulse when the ball passes the right edge.
REQ-006 SHALL have ports: iSERVE_N in 1, asynchronous active-low push-button; iPAUSE in 1, level switch.
REQ-007 SHALL have ports: oBALL_RUN out 1, enables ball movement; oBALL_CENTRE out 1, one-cycle pulse that recentres the ball; oSERVE_DIR out 1, 0 = toward right, 1 = toward left.
REQ-008 SHALL have ports: oSCORE_L out 4 and oSCORE_R out 4, binary scores; oWINNER out 2 (00 none, 01 left, 10 right); oSTATE out 3, the encoded FSM state for debug.

Function
REQ-009 SHALL pass iSERVE_N through a 2-flop synchroniser, then a falling-edge detector, to produce serve_evt: one cycle per press, 3 cycles of latency.
REQ-010 SHALL implement states IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4. Unused encodings SHALL go to IDLE on the next cycle.
REQ-011 IDLE: oBALL_RUN=0. On serve_evt, SHALL pulse oBALL_CENTRE, load the frame counter with SERVE_FRAMES, and go to SERVE.
REQ-012 SERVE: the counter SHALL decrement only on cycles with iFRAME. When it reaches 0, the FSM SHALL go to RALLY on the next cycle.
REQ-013 RALLY: oBALL_RUN = ~iPAUSE. iFRAME, iMISS_L and iMISS_R SHALL still be accepted while paused.
REQ-014 RALLY, iMISS_L only: oSCORE_R SHALL increment, oSERVE_DIR SHALL become 1 (serve toward the loser), and the FSM SHALL go to POINT.
REQ-015 RALLY, iMISS_R only: oSCORE_L SHALL increment, oSERVE_DIR SHALL become 0, and the FSM SHALL go to POINT.
REQ-016 RALLY, iMISS_L and iMISS_R in the same cycle: no score change, oSERVE_DIR SHALL toggle, and the FSM SHALL go to POINT.
REQ-017 Miss pulses outside RALLY SHALL be ignored.
REQ-018 On entry to POINT, the counter SHALL load POINT_FRAMES and oBALL_RUN SHALL be 0.
REQ-019 When the POINT count reaches 0: if either score equals WIN_SCORE, SHALL set oWINNER and go to OVER; otherwise SHALL pulse oBALL_CENTRE, reload SERVE_FRAMES, and go to SERVE.
REQ-020 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-021 OVER: oBALL_RUN=0 and scores held. On serve_evt, SHALL clear scores and oWINNER, pulse oBALL_CENTRE, keep oSERVE_DIR, and go to SERVE.
REQ-022 serve_evt SHALL be ignored in SERVE, RALLY and POINT.
REQ-023 All outputs SHALL be registered.
REQ-024 oBALL_CENTRE SHALL be high for exactly one cycle per transition into SERVE.
REQ-025 The frame counter SHALL be wide enough for max(SERVE_FRAMES, POINT_FRAMES) and SHALL never underflow: it holds at 0.
REQ-026 An iFRAME coinciding with a state-entry cycle SHALL NOT decrement the freshly loaded counter.

Reset
REQ-027 While iRST_N=0 at a rising iclk edge: state=IDLE, counter=0, oSCORE_L=oSCORE_R=0, oWINNER=00, oSERVE_DIR=0, oBALL_RUN=0, oBALL_CENTRE=0, and synchroniser flops=1 (button released).
REQ-028 Reset asserted mid-operation in any state SHALL take effect at the next edge and abandon any pending point or countdown.

Structure
REQ-029 A shared package pong_pkg SHALL hold the state encodings, the oWINNER encodings and the default WIN_SCORE/SERVE_FRAMES/POINT_FRAMES constants.
REQ-030 The synchroniser and edge detector SHALL be one sub-module, btn_edge, reused later for paddle keys.
REQ-031 Score-to-HEX display SHALL stay outside this block.

Verification
REQ-032 Reset then press serve -> oBALL_CENTRE one pulse, oSTATE=1; after 60 iFRAME pulses -> oSTATE=2, oBALL_RUN=1.
REQ-033 In RALLY pulse iMISS_R -> oSCORE_L=1, oSERVE_DIR=0, oBALL_RUN=0; after 90 frames -> oBALL_CENTRE pulse, SERVE.
REQ-034 Drive scores to 6-0 then iMISS_R -> oSCORE_L=7; after 90 frames -> oWINNER=01, oSTATE=4; serve -> scores 0/0, oWINNER=00, oSTATE=1.
REQ-035 iMISS_L and iMISS_R same cycle with oSERVE_DIR=0 -> scores unchanged, oSERVE_DIR=1, oSTATE=3.
REQ-036 RALLY with iPAUSE=1 -> oBALL_RUN=0; iMISS_L still gives oSCORE_R+1; a serve press in SERVE/RALLY/POINT causes no change.
REQ-037 Reset pulse mid-POINT with score 3-2 -> next cycle all outputs at REQ-027 values; a 1-cycle serve glitch held <2 cycles after release still yields exactly one serve_evt.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings and default timing constants for the pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam int unsigned DEF_WIN_SCORE    = 7;
    localparam int unsigned DEF_SERVE_FRAMES = 60;
    localparam int unsigned DEF_POINT_FRAMES = 90;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus falling-edge detector for an active-low button;
// emits a registered one-cycle pulse three cycles after the press.
module btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic fall_o
);

    logic [2:0] sync_q;
    logic       fall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], btn_ni};
            // sync_q[2] is the previous synchronised level
            fall_q <= sync_q[2] & ~sync_q[1];
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencing: serve countdown, rally, point hold, scoring and game over.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
    parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int unsigned POINT_FRAMES = DEF_POINT_FRAMES
) (
    input  logic       iclk,
    input  logic       iRST_N,
    input  logic       iFRAME,
    input  logic       iMISS_L,
    input  logic       iMISS_R,
    input  logic       iSERVE_N,
    input  logic       iPAUSE,
    output logic       oBALL_RUN,
    output logic       oBALL_CENTRE,
    output logic       oSERVE_DIR,
    output logic [3:0] oSCORE_L,
    output logic [3:0] oSCORE_R,
    output logic [1:0] oWINNER,
    output logic [2:0] oSTATE
);

    localparam int unsigned CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES);
    localparam logic [CW-1:0] POINT_LD = CW'(POINT_FRAMES);
    localparam logic [3:0]    WIN4     = 4'(WIN_SCORE);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      sl_q, sl_d, sr_q, sr_d;
    logic [1:0]      win_q, win_d;
    logic            dir_q, dir_d;
    logic            run_q, run_d;
    logic            centre_q, centre_d;
    logic            serve_evt;

    btn_edge u_serve_btn (
        .clk_i  (iclk),
        .rst_ni (iRST_N),
        .btn_ni (iSERVE_N),
        .fall_o (serve_evt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sl_d     = sl_q;
        sr_d     = sr_q;
        win_d    = win_q;
        dir_d    = dir_q;
        centre_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (serve_evt) begin
                    centre_d = 1'b1;
                    cnt_d    = SERVE_LD;
                    state_d  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (cnt_q == '0)  state_d = ST_RALLY;
                else if (iFRAME)  cnt_d   = cnt_q - CW'(1);
            end
            ST_RALLY: begin
                if (iMISS_L || iMISS_R) begin
                    cnt_d   = POINT_LD;
                    state_d = ST_POINT;
                    if (iMISS_L && iMISS_R) begin
                        dir_d = ~dir_q;
                    end else if (iMISS_L) begin
                        if (sr_q < WIN4) sr_d = sr_q + 4'd1;
                        dir_d = 1'b1;
                    end else begin
                        if (sl_q < WIN4) sl_d = sl_q + 4'd1;
                        dir_d = 1'b0;
                    end
                end
            end
            ST_POINT: begin
                if (cnt_q == '0) begin
                    if (sl_q == WIN4 || sr_q == WIN4) begin
                        win_d   = (sl_q == WIN4) ? WIN_LEFT : WIN_RIGHT;
                        state_d = ST_OVER;
                    end else begin
                        centre_d = 1'b1;
                        cnt_d    = SERVE_LD;
                        state_d  = ST_SERVE;
                    end
                end else if (iFRAME) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_OVER: begin
                if (serve_evt) begin
                    sl_d     = '0;
                    sr_d     = '0;
                    win_d    = WIN_NONE;
                    centre_d = 1'b1;
                    cnt_d    = SERVE_LD;
                    state_d  = ST_SERVE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Run is registered from the next state so it drops on the very cycle POINT is entered
        run_d = (state_d == ST_RALLY) && !iPAUSE;
    end

    always_ff @(posedge iclk) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sl_q     <= '0;
            sr_q     <= '0;
            win_q    <= WIN_NONE;
            dir_q    <= 1'b0;
            run_q    <= 1'b0;
            centre_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
            win_q    <= win_d;
            dir_q    <= dir_d;
            run_q    <= run_d;
            centre_q <= centre_d;
        end
    end

    assign oBALL_RUN    = run_q;
    assign oBALL_CENTRE = centre_q;
    assign oSERVE_DIR   = dir_q;
    assign oSCORE_L     = sl_q;
    assign oSCORE_R     = sr_q;
    assign oWINNER      = win_q;
    assign oSTATE       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: per-cycle vector table for reset/serve,
// then hand-written sequences for countdowns, scoring, game over and reset.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, frame, miss_l, miss_r, serve_n, pause;
    logic       run, centre, dir;
    logic [3:0] sl, sr;
    logic [1:0] win;
    logic [2:0] st;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(.WIN_SCORE(7), .SERVE_FRAMES(60), .POINT_FRAMES(90)) dut (
        .iclk         (clk),
        .iRST_N       (rst_n),
        .iFRAME       (frame),
        .iMISS_L      (miss_l),
        .iMISS_R      (miss_r),
        .iSERVE_N     (serve_n),
        .iPAUSE       (pause),
        .oBALL_RUN    (run),
        .oBALL_CENTRE (centre),
        .oSERVE_DIR   (dir),
        .oSCORE_L     (sl),
        .oSCORE_R     (sr),
        .oWINNER      (win),
        .oSTATE       (st)
    );

    typedef struct {
        logic       rst_n;
        logic       serve_n;
        logic [2:0] st;
        logic       centre;
        logic       run;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] win;
        logic       dir;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            step();
            frame = 1'b0;
            step();
        end
    endtask

    task automatic miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        step();
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    // Full point ending back in RALLY; left scores when the right side misses
    task automatic win_point(input logic left_scores);
        miss(!left_scores, left_scores);
        frames(90);
        frames(60);
    endtask

    task automatic press_count(input int low_cycles, input int window, output int pulses);
        pulses = 0;
        serve_n = 1'b0;
        for (int i = 0; i < window; i++) begin
            if (i == low_cycles) serve_n = 1'b1;
            step();
            if (centre) pulses++;
        end
        serve_n = 1'b1;
    endtask

    initial begin
        int p;
        rst_n = 1'b0; frame = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        serve_n = 1'b1; pause = 1'b0;

        //          rst serve st    ctr run sl    sr    win    dir
        tbl[0] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0};

        step();
        for (int i = 0; i < 6; i++) begin
            rst_n   = tbl[i].rst_n;
            serve_n = tbl[i].serve_n;
            step();
            chk($sformatf("vec%0d_state", i),  st,     tbl[i].st);
            chk($sformatf("vec%0d_centre", i), centre, tbl[i].centre);
            chk($sformatf("vec%0d_run", i),    run,    tbl[i].run);
            chk($sformatf("vec%0d_scoreL", i), sl,     tbl[i].sl);
            chk($sformatf("vec%0d_scoreR", i), sr,     tbl[i].sr);
            chk($sformatf("vec%0d_winner", i), win,    tbl[i].win);
            chk($sformatf("vec%0d_dir", i),    dir,    tbl[i].dir);
        end

        // Serve countdown boundary
        frames(59);
        chk("serve_59_state", st, 1);
        frames(1);
        chk("serve_60_state", st, 2);
        chk("serve_60_run", run, 1);

        // Right miss scores for the left
        miss(1'b0, 1'b1);
        chk("missR_scoreL", sl, 1);
        chk("missR_dir", dir, 0);
        chk("missR_run", run, 0);
        chk("missR_state", st, 3);
        frames(89);
        chk("point_89_state", st, 3);
        frames(1);
        chk("point_90_state", st, 1);
        chk("point_90_centre", centre, 1);
        step();
        chk("point_centre_once", centre, 0);
        frames(60);

        // Drive to 6-0, then the winning point
        for (int i = 0; i < 5; i++) win_point(1'b1);
        chk("six_nil_scoreL", sl, 6);
        miss(1'b0, 1'b1);
        chk("seven_scoreL", sl, 7);
        frames(90);
        chk("over_state", st, 4);
        chk("over_winner", win, 1);
        chk("over_run", run, 0);
        miss(1'b0, 1'b1);
        chk("over_miss_ignored", sl, 7);
        press_count(2, 10, p);
        chk("over_serve_pulses", p, 1);
        chk("restart_state", st, 1);
        chk("restart_scoreL", sl, 0);
        chk("restart_scoreR", sr, 0);
        chk("restart_winner", win, 0);
        chk("restart_dir_kept", dir, 0);
        frames(60);

        // Simultaneous misses
        miss(1'b1, 1'b1);
        chk("both_scoreL", sl, 0);
        chk("both_scoreR", sr, 0);
        chk("both_dir", dir, 1);
        chk("both_state", st, 3);
        frames(90);
        frames(60);

        // Pause and ignored serve presses
        pause = 1'b1;
        step();
        chk("pause_run", run, 0);
        chk("pause_state", st, 2);
        press_count(2, 8, p);
        chk("rally_press_pulses", p, 0);
        chk("rally_press_state", st, 2);
        miss(1'b1, 1'b0);
        chk("paused_missL_scoreR", sr, 1);
        chk("paused_missL_dir", dir, 1);
        chk("paused_missL_state", st, 3);
        press_count(2, 8, p);
        chk("point_press_pulses", p, 0);
        chk("point_press_state", st, 3);
        pause = 1'b0;
        frames(90);
        press_count(2, 8, p);
        chk("serve_press_pulses", p, 0);
        chk("serve_press_state", st, 1);
        frames(60);
        chk("unpause_run", run, 1);

        // Reach 3-2 and reset mid-POINT
        win_point(1'b1);
        win_point(1'b1);
        win_point(1'b0);
        miss(1'b0, 1'b1);
        chk("three_two_scoreL", sl, 3);
        chk("three_two_scoreR", sr, 2);
        frames(10);
        rst_n = 1'b0;
        step();
        chk("rst_state", st, 0);
        chk("rst_run", run, 0);
        chk("rst_centre", centre, 0);
        chk("rst_scoreL", sl, 0);
        chk("rst_scoreR", sr, 0);
        chk("rst_winner", win, 0);
        chk("rst_dir", dir, 0);
        rst_n = 1'b1;
        frames(100);
        chk("rst_abandon_state", st, 0);

        // One-cycle serve glitch
        press_count(1, 10, p);
        chk("glitch_pulses", p, 1);
        chk("glitch_state", st, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
